registerfile_mp: RTL and testbench
==================================

// Module: registerfile_mp
// PURPOSE
//  Parametrised multi-port register file: next generation of the single-cycle core's RF.
//  - Two write ports: A = ALU result, B = load/late result. N read ports.
//  - One index is reserved as the PC alias and returns the pc input.
//  - Optional write-to-read bypass.
//  - Per-register busy scoreboard, so the pipelined core can stall on pending loads.
// PARAMETERS
//  DW      32  data width in bits
//  NREG    16  architectural registers, including the PC alias (power of 2, >=4)
//  AW      4   index width, = $clog2(NREG)
//  NRD     3   number of read ports (>=1)
//  PC_IDX  15  index aliased to pc_in; never stored
//  BYPASS  1   1: same-cycle write data forwarded to reads; 0: reads see stored value only
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  we_a        in   1       write enable, port A
//  wa_a        in   AW      write index, port A
//  wd_a        in   DW      write data, port A
//  we_b        in   1       write enable, port B (load return)
//  wa_b        in   AW      write index, port B
//  wd_b        in   DW      write data, port B
//  ra          in   NRD*AW  read indices; port i = ra[i*AW +: AW]
//  rd          out  NRD*DW  read data; port i = rd[i*DW +: DW]
//  rd_busy     out  NRD     1: register addressed by read port i has a pending load
//  pc_in       in   DW      value returned for reads of PC_IDX
//  busy_set    in   1       mark register busy_idx pending (load issued)
//  busy_idx    in   AW      register to mark pending
//  any_busy    out  1       OR of all busy bits
// BEHAVIOUR
//  Reset (reset_n=0, async): all stored registers = 0, all busy bits = 0.
//   - rd therefore reads 0 for every non-PC index; rd_busy=0; any_busy=0.
//   - Reset asserted mid-cycle clears state immediately. Writes are ignored while reset_n=0.
//  Writes: take effect on the rising clk edge.
//   - A write with index == PC_IDX is dropped on either port (no storage exists).
//   - we_a & we_b to the same index: port B wins; port A data is discarded.
//  Reads: combinational, zero latency, evaluated independently per port.
//   - ra == PC_IDX -> pc_in, regardless of any write or BYPASS.
//   - BYPASS=1: ra == wa_b & we_b -> wd_b; else ra == wa_a & we_a -> wd_a; else stored value.
//   - BYPASS=0: stored value (pre-edge).
//  Scoreboard: one busy bit per non-PC register, updated on the rising clk edge.
//   - Set: busy_set=1 sets busy[busy_idx]. Ignored when busy_idx == PC_IDX.
//   - Clear: we_b=1 clears busy[wa_b]. A port A write does not clear busy.
//   - busy_set and we_b to the same index in one cycle: set wins; the bit stays 1.
//   - rd_busy[i] = busy[ra_i].
//     Exceptions: 0 when ra_i == PC_IDX; with BYPASS=1, also 0 when we_b & wa_b == ra_i.
//   - any_busy = |busy, registered state only.
//  Widths: no arithmetic. wd_* are stored verbatim. Indices >= NREG (if NREG < 2**AW): write dropped, read returns 0.
// TESTING
//  1. Reset: pulse reset_n low between edges after writing r3=0x1234
//     -> rd of r3 = 0 immediately; any_busy = 0.
//  2. Basic write/read: we_a, wa_a=2, wd_a=0xDEADBEEF.
//     -> BYPASS=1: rd0 = 0xDEADBEEF in the same cycle. BYPASS=0: visible only after the edge.
//  3. Dual write collision: we_a, we_b both to r5, wd_a=0x11, wd_b=0x22
//     -> r5 = 0x22 after the edge; bypassed read in that cycle = 0x22.
//  4. PC alias: pc_in=0x80, ra=15, we_a to 15 with 0xFF
//     -> rd = 0x80 before and after the edge; no storage change.
//  5. Scoreboard:
//     - busy_set idx 7 -> rd_busy=1 on r7, any_busy=1.
//     - Next, we_b to r7 with 0x55 -> rd_busy=0 in that cycle (BYPASS=1); busy clear after the edge.
//  6. Set/clear collision: busy_set idx 4 and we_b wa_b=4 in the same cycle
//     -> busy[4] = 1 after the edge; r4 holds wd_b.

Source files
------------

// File: rtl/registerfile_mp.sv
// Multi-port register file: two write ports (B wins on collision), NRD combinational
// read ports with optional write bypass, a PC alias index and a per-register load scoreboard.

module registerfile_mp_rdport #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int PC_IDX = 15,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]             ra,
    input  logic [NREG-1:0][DW-1:0]   regs,
    input  logic [NREG-1:0]           busy,
    input  logic                      we_a,
    input  logic [AW-1:0]             wa_a,
    input  logic [DW-1:0]             wd_a,
    input  logic                      we_b,
    input  logic [AW-1:0]             wa_b,
    input  logic [DW-1:0]             wd_b,
    input  logic [DW-1:0]             pc_in,
    output logic [DW-1:0]             rd,
    output logic                      rd_busy
);
    logic in_rng, is_pc, hit_a, hit_b;

    assign in_rng = 32'(ra) < NREG;
    assign is_pc  = 32'(ra) == PC_IDX;
    assign hit_b  = (BYPASS != 0) && we_b && (wa_b == ra);
    assign hit_a  = (BYPASS != 0) && we_a && (wa_a == ra);

    // A bypassed port B write is the load returning, so it also hides the busy bit.
    always_comb begin
        rd      = '0;
        rd_busy = 1'b0;
        if (is_pc) begin
            rd = pc_in;
        end else if (in_rng) begin
            if (hit_b)      rd = wd_b;
            else if (hit_a) rd = wd_a;
            else            rd = regs[ra];
            rd_busy = busy[ra] && !hit_b;
        end
    end
endmodule

module registerfile_mp #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int NRD    = 3,
    parameter int PC_IDX = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_a,
    input  logic [AW-1:0]     wa_a,
    input  logic [DW-1:0]     wd_a,
    input  logic              we_b,
    input  logic [AW-1:0]     wa_b,
    input  logic [DW-1:0]     wd_b,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic [DW-1:0]     pc_in,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_idx,
    output logic              any_busy
);
    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         busy_q, busy_d;

    // Only real storage slots can be written or marked; PC alias and out-of-range drop.
    function automatic logic stored(input logic [AW-1:0] idx);
        return (32'(idx) < NREG) && (32'(idx) != PC_IDX);
    endfunction

    // Port B applied after A so it wins; set applied after clear so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we_a && stored(wa_a)) regs_d[wa_a] = wd_a;
        if (we_b && stored(wa_b)) begin
            regs_d[wa_b] = wd_b;
            busy_d[wa_b] = 1'b0;
        end
        if (busy_set && stored(busy_idx)) busy_d[busy_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign any_busy = |busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        registerfile_mp_rdport #(
            .DW(DW), .NREG(NREG), .AW(AW), .PC_IDX(PC_IDX), .BYPASS(BYPASS)
        ) u_rd (
            .ra      (ra[i*AW +: AW]),
            .regs    (regs_q),
            .busy    (busy_q),
            .we_a    (we_a),
            .wa_a    (wa_a),
            .wd_a    (wd_a),
            .we_b    (we_b),
            .wa_b    (wa_b),
            .wd_b    (wd_b),
            .pc_in   (pc_in),
            .rd      (rd[i*DW +: DW]),
            .rd_busy (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_registerfile_mp.sv
// Bench for registerfile_mp: one BYPASS=1 and one BYPASS=0 instance on shared inputs,
// a hand-computed vector table, a reset sequence and random traffic against an array model.

module tb_registerfile_mp;
    localparam int DW = 32, AW = 4, NRD = 3, NREG = 16, PCI = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              we_a, we_b, busy_set;
    logic [AW-1:0]     wa_a, wa_b, busy_idx;
    logic [DW-1:0]     wd_a, wd_b, pc_in;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd1, rd0;
    logic [NRD-1:0]    rb1, rb0;
    logic              any1, any0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    registerfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .ra(ra), .rd(rd1), .rd_busy(rb1),
        .pc_in(pc_in), .busy_set(busy_set), .busy_idx(busy_idx), .any_busy(any1));

    registerfile_mp #(.BYPASS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .ra(ra), .rd(rd0), .rd_busy(rb0),
        .pc_in(pc_in), .busy_set(busy_set), .busy_idx(busy_idx), .any_busy(any0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        busy_set = 1'b0; busy_idx = '0;
    endtask

    typedef struct {
        logic        we_a; logic [3:0] wa_a; logic [31:0] wd_a;
        logic        we_b; logic [3:0] wa_b; logic [31:0] wd_b;
        logic        bset; logic [3:0] bidx; logic [3:0]  ra0;
        logic [31:0] e_rd1; logic e_bz1; logic [31:0] e_rd0; logic e_bz0; logic e_any;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic a, input logic [3:0] aa, input logic [31:0] ad,
                        input logic b, input logic [3:0] ba, input logic [31:0] bd,
                        input logic s, input logic [3:0] si, input logic [3:0] r,
                        input logic [31:0] er1, input logic eb1,
                        input logic [31:0] er0, input logic eb0, input logic ea);
        vec_t v;
        v.we_a = a; v.wa_a = aa; v.wd_a = ad; v.we_b = b; v.wa_b = ba; v.wd_b = bd;
        v.bset = s; v.bidx = si; v.ra0 = r;
        v.e_rd1 = er1; v.e_bz1 = eb1; v.e_rd0 = er0; v.e_bz0 = eb0; v.e_any = ea;
        tbl.push_back(v);
    endtask

    // Reference model: architectural contents and pending-load flags.
    logic [31:0] mregs [NREG];
    logic        mbusy [NREG];

    function automatic logic [31:0] m_rd(input bit byp, input logic [3:0] idx);
        if (idx == 4'(PCI)) return pc_in;
        if (byp && we_b && wa_b == idx) return wd_b;
        if (byp && we_a && wa_a == idx) return wd_a;
        return mregs[idx];
    endfunction

    function automatic logic m_bz(input bit byp, input logic [3:0] idx);
        if (idx == 4'(PCI)) return 1'b0;
        if (byp && we_b && wa_b == idx) return 1'b0;
        return mbusy[idx];
    endfunction

    function automatic logic m_any();
        logic r = 1'b0;
        for (int k = 0; k < NREG; k++) r |= mbusy[k];
        return r;
    endfunction

    task automatic m_edge();
        if (we_a && wa_a != 4'(PCI)) mregs[wa_a] = wd_a;
        if (we_b && wa_b != 4'(PCI)) begin
            mregs[wa_b] = wd_b;
            mbusy[wa_b] = 1'b0;
        end
        if (busy_set && busy_idx != 4'(PCI)) mbusy[busy_idx] = 1'b1;
    endtask

    function automatic logic [3:0] pick();
        int r = $urandom_range(0, 9);
        return (r == 9) ? 4'(PCI) : 4'(r);
    endfunction

    initial begin
        idle();
        reset_n = 1'b0;
        pc_in   = 32'h80;
        ra      = '0;
        #12;
        chk("reset_rd0", rd1[DW-1:0], 32'h0);
        chk("reset_any", {31'b0, any1}, 32'h0);
        chk("reset_rbusy", {29'b0, rb1}, 32'h0);
        reset_n = 1'b1;

        // Reset sequence: r3 written and marked busy, then reset dropped mid-cycle.
        @(negedge clk);
        we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h1234; busy_set = 1'b1; busy_idx = 4'd3;
        @(posedge clk);
        @(negedge clk);
        idle(); ra = {3{4'd3}};
        #1;
        chk("pre_reset_r3", rd1[DW-1:0], 32'h1234);
        chk("pre_reset_any", {31'b0, any1}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_r3", rd1[DW-1:0], 32'h0);
        chk("async_reset_r3_nb", rd0[DW-1:0], 32'h0);
        chk("async_reset_any", {31'b0, any1}, 32'h0);
        we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h77;
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("write_in_reset_ignored", rd1[DW-1:0], 32'h0);
        reset_n = 1'b1;

        // Hand-computed vectors from the reset state; r_pc = 0x80.
        addv(1'b1, 4'd2, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        addv(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 4'd0, 4'd5, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 32'h22, 1'b0, 32'h22, 1'b0, 1'b0);
        addv(1'b1, 4'd15, 32'hFF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 32'h80, 1'b0, 32'h80, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 32'h80, 1'b0, 32'h80, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h55, 1'b0, 4'd0, 4'd7, 32'h55, 1'b0, 32'h0, 1'b1, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 32'h55, 1'b0, 32'h55, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h99, 1'b1, 4'd4, 4'd4, 32'h99, 1'b0, 32'h0, 1'b0, 1'b0);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 32'h99, 1'b1, 32'h99, 1'b1, 1'b1);
        addv(1'b1, 4'd4, 32'h33, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 32'h33, 1'b1, 32'h99, 1'b1, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 32'h33, 1'b1, 32'h33, 1'b1, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd15, 32'h80, 1'b0, 32'h80, 1'b0, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 32'h80, 1'b0, 32'h80, 1'b0, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'hAA, 1'b0, 4'd0, 4'd4, 32'hAA, 1'b0, 32'h33, 1'b1, 1'b1);
        addv(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 32'hAA, 1'b0, 32'hAA, 1'b0, 1'b0);

        foreach (tbl[n]) begin
            @(negedge clk);
            we_a = tbl[n].we_a; wa_a = tbl[n].wa_a; wd_a = tbl[n].wd_a;
            we_b = tbl[n].we_b; wa_b = tbl[n].wa_b; wd_b = tbl[n].wd_b;
            busy_set = tbl[n].bset; busy_idx = tbl[n].bidx;
            ra = {3{tbl[n].ra0}};
            #1;
            chk($sformatf("vec%0d_rd_byp", n), rd1[DW-1:0], tbl[n].e_rd1);
            chk($sformatf("vec%0d_busy_byp", n), {31'b0, rb1[0]}, {31'b0, tbl[n].e_bz1});
            chk($sformatf("vec%0d_rd_nobyp", n), rd0[DW-1:0], tbl[n].e_rd0);
            chk($sformatf("vec%0d_busy_nobyp", n), {31'b0, rb0[0]}, {31'b0, tbl[n].e_bz0});
            chk($sformatf("vec%0d_any", n), {30'b0, any1, any0}, {30'b0, tbl[n].e_any, tbl[n].e_any});
        end

        // Random traffic from a fresh reset against the array model.
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            mregs[k] = '0;
            mbusy[k] = 1'b0;
        end
        #2 reset_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we_a = 1'($urandom_range(0, 1)); wa_a = pick(); wd_a = $urandom;
            we_b = 1'($urandom_range(0, 1)); wa_b = pick(); wd_b = $urandom;
            busy_set = 1'($urandom_range(0, 1)); busy_idx = pick();
            pc_in = $urandom;
            ra = {pick(), pick(), pick()};
            #1;
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rnd%0d_p%0d_rd_byp", c, p), rd1[p*DW +: DW], m_rd(1'b1, ra[p*AW +: AW]));
                chk($sformatf("rnd%0d_p%0d_rd_nobyp", c, p), rd0[p*DW +: DW], m_rd(1'b0, ra[p*AW +: AW]));
                chk($sformatf("rnd%0d_p%0d_busy", c, p), {30'b0, rb1[p], rb0[p]},
                    {30'b0, m_bz(1'b1, ra[p*AW +: AW]), m_bz(1'b0, ra[p*AW +: AW])});
            end
            chk($sformatf("rnd%0d_any", c), {30'b0, any1, any0}, {30'b0, m_any(), m_any()});
            m_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
